// File: rtl/apb_mem_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
// Shared types and helpers for the APB-to-SRAM bridge.
//   state_e       : bridge FSM states
//   wordAddrShift : log2 of the bytes per data word, i.e. how far a byte
//                   address is shifted right to become a word address
// ---------------------------------------------------------------------------
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RWAIT,
    RESP
  } state_e;

  function automatic int unsigned wordAddrShift(input int unsigned dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/apb_mem_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_mem_addr_decode
// Purely combinational decode of an APB byte address against the memory
// window.
//   paddr_i    : APB byte address
//   inRange_o  : address lies in [BASE_ADDR, BASE_ADDR + window bytes)
//   aligned_o  : address is aligned to a full data word
//   wordAddr_o : memory word address (offset from BASE_ADDR, in words)
// ---------------------------------------------------------------------------
module apb_mem_addr_decode
  import apb_mem_pkg::*;
#(
  parameter int unsigned                 APB_ADDR_WIDTH = 32,
  parameter int unsigned                 DATA_WIDTH     = 32,
  parameter int unsigned                 MEM_ADDR_WIDTH = 10,
  parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR      = 'h1A10_0000
) (
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  output logic                      inRange_o,
  output logic                      aligned_o,
  output logic [MEM_ADDR_WIDTH-1:0] wordAddr_o
);

  localparam int unsigned Shift   = wordAddrShift(DATA_WIDTH);
  localparam int unsigned WinBits = MEM_ADDR_WIDTH + Shift;

  // The window bounds are compared one bit wider than the bus so that a
  // window ending exactly at the top of the address space does not wrap.
  localparam logic [APB_ADDR_WIDTH:0] WinLo   = {1'b0, BASE_ADDR};
  localparam logic [APB_ADDR_WIDTH:0] WinSize = (APB_ADDR_WIDTH + 1)'(1) << WinBits;
  localparam logic [APB_ADDR_WIDTH:0] WinHi   = WinLo + WinSize;

  localparam logic [APB_ADDR_WIDTH-1:0] AlignMask = APB_ADDR_WIDTH'((1 << Shift) - 1);

  logic [APB_ADDR_WIDTH:0]   addrExt;
  logic [APB_ADDR_WIDTH-1:0] offset;

  assign addrExt    = {1'b0, paddr_i};
  assign inRange_o  = (addrExt >= WinLo) && (addrExt < WinHi);
  assign aligned_o  = ((paddr_i & AlignMask) == '0);
  assign offset     = paddr_i - BASE_ADDR;
  assign wordAddr_o = MEM_ADDR_WIDTH'(offset >> Shift);

endmodule

// File: rtl/apb_mem_bridge.sv
// ---------------------------------------------------------------------------
// apb_mem_bridge
// APB4 slave that turns APB transfers into single-port SRAM accesses.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   paddr_i .. pstrb_i    : APB4 request (address, data, dir, select, strobes)
//   prdata_o, pready_o,   : APB4 response
//   pslverr_o
//   mem_csn_o, mem_wen_o  : active-low chip select / write enable
//   mem_add_o             : memory word address
//   mem_wdata_o, mem_be_o : write data and active-high byte enables
//   mem_rdata_i           : read data, valid READ_LATENCY cycles after the
//                           edge that sampled mem_csn_o low
// Writes and errors complete with zero wait states; reads with
// READ_LATENCY+1 wait states.
// ---------------------------------------------------------------------------
module apb_mem_bridge
  import apb_mem_pkg::*;
#(
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH     = 32,
  parameter int unsigned               MEM_ADDR_WIDTH = 10,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 'h1A10_0000,
  parameter int unsigned               READ_LATENCY   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0]     pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
  output logic [DATA_WIDTH-1:0]     prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic                      memCsn_q, memCsn_d;
  logic                      memWen_q, memWen_d;
  logic [MEM_ADDR_WIDTH-1:0] memAdd_q, memAdd_d;
  logic [DATA_WIDTH-1:0]     memWdata_q, memWdata_d;
  logic [StrbWidth-1:0]      memBe_q, memBe_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic [2:0]                count_q, count_d;
  logic                      err_q, err_d;

  logic                      inRange;
  logic                      aligned;
  logic [MEM_ADDR_WIDTH-1:0] wordAddr;
  logic                      setupPhase;

  apb_mem_addr_decode #(
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
    .BASE_ADDR      (BASE_ADDR)
  ) u_decode (
    .paddr_i    (paddr_i),
    .inRange_o  (inRange),
    .aligned_o  (aligned),
    .wordAddr_o (wordAddr)
  );

  // Only a setup phase seen while idle starts a transfer; psel_i is
  // ignored in every other state so a dropped select cannot derail a
  // sequence already in progress.
  assign setupPhase = psel_i && !penable_i;

  // Next-state logic. The memory strobes default to inactive so that
  // mem_csn_o is a single-cycle pulse, while address/data/enables hold
  // their previous value unless a new access is launched.
  always_comb begin
    state_d    = state_q;
    memCsn_d   = 1'b1;
    memWen_d   = 1'b1;
    memAdd_d   = memAdd_q;
    memWdata_d = memWdata_q;
    memBe_d    = memBe_q;
    prdata_d   = prdata_q;
    count_d    = count_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (setupPhase) begin
          if (!inRange || !aligned) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else if (pwrite_i && (pstrb_i == '0)) begin
            err_d   = 1'b0;
            state_d = ACK;
          end else if (pwrite_i) begin
            err_d      = 1'b0;
            memCsn_d   = 1'b0;
            memWen_d   = 1'b0;
            memAdd_d   = wordAddr;
            memWdata_d = pwdata_i;
            memBe_d    = pstrb_i;
            state_d    = ACK;
          end else begin
            err_d    = 1'b0;
            memCsn_d = 1'b0;
            memAdd_d = wordAddr;
            memBe_d  = '1;
            count_d  = 3'(READ_LATENCY);
            state_d  = RWAIT;
          end
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      // The counter is loaded in the cycle the chip select is low and
      // reaches zero in the cycle the memory presents its data.
      RWAIT: begin
        if (count_q == '0) begin
          prdata_d = mem_rdata_i;
          state_d  = RESP;
        end else begin
          count_d = count_q - 3'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to an idle,
  // deselected memory port immediately, discarding any pending read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      memCsn_q   <= 1'b1;
      memWen_q   <= 1'b1;
      memAdd_q   <= '0;
      memWdata_q <= '0;
      memBe_q    <= '0;
      prdata_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      memCsn_q   <= memCsn_d;
      memWen_q   <= memWen_d;
      memAdd_q   <= memAdd_d;
      memWdata_q <= memWdata_d;
      memBe_q    <= memBe_d;
      prdata_q   <= prdata_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // The APB response is a pure decode of the registered state.
  assign pready_o    = (state_q == ACK) || (state_q == RESP);
  assign pslverr_o   = (state_q == ACK) && err_q;
  assign prdata_o    = prdata_q;
  assign mem_csn_o   = memCsn_q;
  assign mem_wen_o   = memWen_q;
  assign mem_add_o   = memAdd_q;
  assign mem_wdata_o = memWdata_q;
  assign mem_be_o    = memBe_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_bridge
// Directed bench for apb_mem_bridge. Two instances share the APB request
// signals but have separate selects: u_dut1 uses READ_LATENCY=1, u_dut3
// uses READ_LATENCY=3. Each has its own behavioural SRAM model.
// ---------------------------------------------------------------------------
module tb_apb_mem_bridge;

  localparam logic [31:0] Base = 32'h1A10_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel1;
  logic        psel3;
  logic        penable;
  logic [3:0]  pstrb;

  logic [31:0] prdata1, prdata3;
  logic        pready1, pready3;
  logic        pslverr1, pslverr3;
  logic        csn1, csn3;
  logic        wen1, wen3;
  logic [9:0]  add1, add3;
  logic [31:0] wdata1, wdata3;
  logic [3:0]  be1, be3;
  logic [31:0] rdata1, rdata3;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  int vectors;
  int miscompares;

  bit          target3;
  int          obsCycle;
  int          obsCsnCount;
  logic        obsErr;
  logic [31:0] obsRdata;
  logic        obsCsnC1;
  logic        obsWenC1;
  logic [9:0]  obsAddC1;
  logic [3:0]  obsBeC1;
  logic [31:0] obsWdataC1;

  logic        selPready, selPslverr, selCsn, selWen;
  logic [31:0] selPrdata, selWdata;
  logic [9:0]  selAdd;
  logic [3:0]  selBe;

  assign selPready  = target3 ? pready3  : pready1;
  assign selPslverr = target3 ? pslverr3 : pslverr1;
  assign selCsn     = target3 ? csn3     : csn1;
  assign selWen     = target3 ? wen3     : wen1;
  assign selPrdata  = target3 ? prdata3  : prdata1;
  assign selWdata   = target3 ? wdata3   : wdata1;
  assign selAdd     = target3 ? add3     : add1;
  assign selBe      = target3 ? be3      : be1;

  apb_mem_bridge #(.READ_LATENCY(1)) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pwrite_i    (pwrite),
    .psel_i      (psel1),
    .penable_i   (penable),
    .pstrb_i     (pstrb),
    .prdata_o    (prdata1),
    .pready_o    (pready1),
    .pslverr_o   (pslverr1),
    .mem_csn_o   (csn1),
    .mem_wen_o   (wen1),
    .mem_add_o   (add1),
    .mem_wdata_o (wdata1),
    .mem_be_o    (be1),
    .mem_rdata_i (rdata1)
  );

  apb_mem_bridge #(.READ_LATENCY(3)) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pwrite_i    (pwrite),
    .psel_i      (psel3),
    .penable_i   (penable),
    .pstrb_i     (pstrb),
    .prdata_o    (prdata3),
    .pready_o    (pready3),
    .pslverr_o   (pslverr3),
    .mem_csn_o   (csn3),
    .mem_wen_o   (wen3),
    .mem_add_o   (add3),
    .mem_wdata_o (wdata3),
    .mem_be_o    (be3),
    .mem_rdata_i (rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with one cycle of read latency; the read data is only
  // valid for a single cycle so a mistimed capture picks up filler.
  always @(posedge clk) begin
    pipe1 <= 32'hBAD0_BAD0;
    if (!csn1) begin
      if (!wen1) begin
        for (int b = 0; b < 4; b++)
          if (be1[b]) mem1[add1][8*b +: 8] <= wdata1[8*b +: 8];
      end else begin
        pipe1 <= mem1[add1];
      end
    end
  end
  assign rdata1 = pipe1;

  // SRAM model with three cycles of read latency.
  always @(posedge clk) begin
    pipe3[0] <= 32'hBAD3_BAD3;
    if (!csn3) begin
      if (!wen3) begin
        for (int b = 0; b < 4; b++)
          if (be3[b]) mem3[add3][8*b +: 8] <= wdata3[8*b +: 8];
      end else begin
        pipe3[0] <= mem3[add3];
      end
    end
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata3 = pipe3[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One APB transfer, entered just after a rising edge (start of C0) and
  // left just after the completion edge, so consecutive calls run
  // back-to-back. Records C1 memory-port values, csn pulse count, the
  // cycle index of pready and the response.
  task automatic applyStimulus(input bit useL3, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    int cyc;
    bit done;
    target3 = useL3;
    paddr   = addr;
    pwdata  = data;
    pwrite  = wr;
    pstrb   = strb;
    penable = 1'b0;
    psel1   = !useL3;
    psel3   = useL3;
    obsCsnCount = 0;
    obsCycle    = 0;
    @(negedge clk);
    if (selCsn == 1'b0) obsCsnCount++;
    @(posedge clk);
    #1 penable = 1'b1;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc <= 20) begin
      @(negedge clk);
      if (cyc == 1) begin
        obsCsnC1   = selCsn;
        obsWenC1   = selWen;
        obsAddC1   = selAdd;
        obsBeC1    = selBe;
        obsWdataC1 = selWdata;
      end
      if (selCsn == 1'b0) obsCsnCount++;
      if (selPready) begin
        done     = 1'b1;
        obsCycle = cyc;
        obsErr   = selPslverr;
        obsRdata = selPrdata;
      end else begin
        cyc++;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL timeout: observed no pready after %0d cycles, expected pready", cyc);
    end
    @(posedge clk);
    #1;
    psel1   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    target3     = 1'b0;
    rst_n   = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pwrite  = 1'b0;
    psel1   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pstrb   = '0;

    // Reset state
    #12;
    checkOutput("rst csn", 32'(csn1), 32'd1);
    checkOutput("rst wen", 32'(wen1), 32'd1);
    checkOutput("rst pready", 32'(pready1), 32'd0);
    checkOutput("rst pslverr", 32'(pslverr1), 32'd0);
    checkOutput("rst prdata", prdata1, 32'd0);
    checkOutput("rst add", 32'(add1), 32'd0);
    checkOutput("rst be", 32'(be1), 32'd0);
    checkOutput("rst wdata", wdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] full write, L=1");
    applyStimulus(1'b0, 1'b1, Base + 32'h10, 32'hDEAD_BEEF, 4'hF);
    checkOutput("wr csn C1", 32'(obsCsnC1), 32'd0);
    checkOutput("wr wen C1", 32'(obsWenC1), 32'd0);
    checkOutput("wr add C1", 32'(obsAddC1), 32'd4);
    checkOutput("wr be C1", 32'(obsBeC1), 32'hF);
    checkOutput("wr wdata C1", obsWdataC1, 32'hDEAD_BEEF);
    checkOutput("wr ready cyc", 32'(obsCycle), 32'd1);
    checkOutput("wr err", 32'(obsErr), 32'd0);
    checkOutput("wr csn pulses", 32'(obsCsnCount), 32'd1);

    $display("[TB] read back, L=1");
    applyStimulus(1'b0, 1'b0, Base + 32'h10, 32'h0, 4'h0);
    checkOutput("rd csn C1", 32'(obsCsnC1), 32'd0);
    checkOutput("rd wen C1", 32'(obsWenC1), 32'd1);
    checkOutput("rd be C1", 32'(obsBeC1), 32'hF);
    checkOutput("rd ready cyc L1", 32'(obsCycle), 32'd3);
    checkOutput("rd data L1", obsRdata, 32'hDEAD_BEEF);
    checkOutput("rd err", 32'(obsErr), 32'd0);

    $display("[TB] partial strobe write");
    applyStimulus(1'b0, 1'b1, Base + 32'h10, 32'h1122_3344, 4'b0101);
    checkOutput("pwr be C1", 32'(obsBeC1), 32'h5);
    checkOutput("pwr ready cyc", 32'(obsCycle), 32'd1);
    applyStimulus(1'b0, 1'b0, Base + 32'h10, 32'h0, 4'h0);
    checkOutput("pwr readback", obsRdata, 32'hDE22_BE44);

    $display("[TB] zero strobe write");
    applyStimulus(1'b0, 1'b1, Base + 32'h10, 32'hFFFF_FFFF, 4'h0);
    checkOutput("zstrb csn pulses", 32'(obsCsnCount), 32'd0);
    checkOutput("zstrb ready cyc", 32'(obsCycle), 32'd1);
    checkOutput("zstrb err", 32'(obsErr), 32'd0);
    checkOutput("prdata held", obsRdata, 32'hDE22_BE44);
    applyStimulus(1'b0, 1'b0, Base + 32'h10, 32'h0, 4'h0);
    checkOutput("zstrb readback", obsRdata, 32'hDE22_BE44);

    $display("[TB] address errors");
    applyStimulus(1'b0, 1'b0, Base + 32'd4096, 32'h0, 4'h0);
    checkOutput("oor csn pulses", 32'(obsCsnCount), 32'd0);
    checkOutput("oor ready cyc", 32'(obsCycle), 32'd1);
    checkOutput("oor err", 32'(obsErr), 32'd1);
    applyStimulus(1'b0, 1'b0, Base + 32'd2, 32'h0, 4'h0);
    checkOutput("unal csn pulses", 32'(obsCsnCount), 32'd0);
    checkOutput("unal ready cyc", 32'(obsCycle), 32'd1);
    checkOutput("unal err", 32'(obsErr), 32'd1);
    applyStimulus(1'b0, 1'b1, Base - 32'd4, 32'h5555_5555, 4'hF);
    checkOutput("below csn pulses", 32'(obsCsnCount), 32'd0);
    checkOutput("below err", 32'(obsErr), 32'd1);

    $display("[TB] last word of window");
    applyStimulus(1'b0, 1'b1, Base + 32'hFFC, 32'h0BAD_F00D, 4'hF);
    checkOutput("last add C1", 32'(obsAddC1), 32'h3FF);
    checkOutput("last err", 32'(obsErr), 32'd0);
    applyStimulus(1'b0, 1'b0, Base + 32'hFFC, 32'h0, 4'h0);
    checkOutput("last readback", obsRdata, 32'h0BAD_F00D);

    $display("[TB] back-to-back write then read");
    applyStimulus(1'b0, 1'b1, Base + 32'h20, 32'hCAFE_F00D, 4'hF);
    checkOutput("b2b wr add", 32'(obsAddC1), 32'd8);
    applyStimulus(1'b0, 1'b0, Base + 32'h20, 32'h0, 4'h0);
    checkOutput("b2b rd cyc", 32'(obsCycle), 32'd3);
    checkOutput("b2b rd data", obsRdata, 32'hCAFE_F00D);

    $display("[TB] read latency 3");
    applyStimulus(1'b1, 1'b1, Base + 32'h10, 32'hDEAD_BEEF, 4'hF);
    checkOutput("L3 wr cyc", 32'(obsCycle), 32'd1);
    applyStimulus(1'b1, 1'b0, Base + 32'h10, 32'h0, 4'h0);
    checkOutput("L3 rd cyc", 32'(obsCycle), 32'd5);
    checkOutput("L3 rd data", obsRdata, 32'hDEAD_BEEF);

    $display("[TB] reset during read wait");
    target3 = 1'b1;
    paddr   = Base + 32'h10;
    pwrite  = 1'b0;
    pstrb   = 4'h0;
    psel3   = 1'b1;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pre-rst pready", 32'(pready3), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-rst csn", 32'(csn3), 32'd1);
    checkOutput("mid-rst wen", 32'(wen3), 32'd1);
    checkOutput("mid-rst pready", 32'(pready3), 32'd0);
    checkOutput("mid-rst prdata", prdata3, 32'd0);
    checkOutput("mid-rst add", 32'(add3), 32'd0);
    checkOutput("mid-rst be", 32'(be3), 32'd0);
    @(negedge clk);
    psel3   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post-rst pready", 32'(pready3), 32'd0);
    checkOutput("post-rst prdata", prdata3, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, Base + 32'h10, 32'h0, 4'h0);
    checkOutput("post-rst rd cyc", 32'(obsCycle), 32'd5);
    checkOutput("post-rst rd data", obsRdata, 32'hDEAD_BEEF);
    checkOutput("post-rst rd err", 32'(obsErr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
